// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues one word fetch at a
// time to instruction memory and buffers returned words in a small FIFO. The
// FIFO head goes to decode through a valid/ready handshake. opcode is simply
// instr[31:26] for the control unit. A redirect from the datapath (taken
// branch or jump) flushes the FIFO and restarts fetch at the new PC. A fetch
// that is still in flight at that moment has its response discarded.
//
// Parameters
//   PC_W      PC / address width
//   RESET_PC  first fetch address after reset (word aligned)
//   DEPTH     FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   imem_req, imem_addr              fetch request and its word address
//   imem_gnt                         memory accepted the request this cycle
//   imem_rvalid, imem_rdata          response strobe and instruction word
//   instr_valid, instr, instr_pc     FIFO head, presented to decode
//   opcode                           instr[31:26]
//   instr_ready                      decode takes the head this cycle
//   redirect_valid, redirect_pc      resolved branch/jump target (bits[1:0]
//                                    are ignored)
//
// Optional feature (macro IFU_PERF_CNT_EN)
//   When IFU_PERF_CNT_EN is defined, two saturating 32-bit counters are added:
//   perf_fetch_cnt (decode handshakes) and perf_flush_cnt (redirect cycles).
//   When the macro is not defined these ports and counters do not exist.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic [5:0]      opcode,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]      state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic [PC_W-1:0] req_pc_reg;          // address of the request in flight
    logic            outstanding_reg, outstanding_next;
    logic            drop_reg, drop_next; // in-flight response is wrong-path
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg, count_next;

    logic [31:0]     fifo_instr_mem [DEPTH];
    logic [PC_W-1:0] fifo_pc_mem    [DEPTH];

    // ---------------------------------------------------------------------
    // Handshake events
    // ---------------------------------------------------------------------
    logic            req_fire;
    logic            rsp_accept;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~PC_W'(3);

    // A request is only presented while nothing is in flight. This also
    // covers the wait for a dropped response after a redirect, during which
    // the FSM already sits in REQ.
    assign imem_req  = (state_reg == ST_REQ) && !outstanding_reg;
    assign imem_addr = pc_reg;

    assign req_fire   = imem_req && imem_gnt;
    // Responses with nothing in flight (stale, or spurious) are ignored.
    assign rsp_accept = outstanding_reg && imem_rvalid;
    assign pop        = instr_valid && instr_ready;
    // A response arriving in a redirect cycle is already wrong-path. The room
    // term never blocks in practice because issue is gated on free space.
    assign push       = rsp_accept && !drop_reg && !redirect_valid &&
                        ((count_reg < DEPTH_C) || pop);

    // ---------------------------------------------------------------------
    // FIFO occupancy. The handshake of a redirect cycle still counts as a
    // consumed instruction, then everything left is flushed.
    // ---------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (redirect_valid) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Outstanding / drop tracking
    // ---------------------------------------------------------------------
    always_comb begin
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        if (rsp_accept) begin
            outstanding_next = 1'b0;
            drop_next        = 1'b0;
        end
        if (req_fire) begin
            outstanding_next = 1'b1;
            // Granted in the same cycle as a redirect: already wrong-path.
            drop_next        = redirect_valid;
        end else if (redirect_valid && outstanding_next) begin
            drop_next        = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // PC
    // ---------------------------------------------------------------------
    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (req_fire) begin
            pc_next = pc_reg + PC_W'(4);   // wraps modulo 2^PC_W
        end
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = ST_REQ;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ: begin
                    if (req_fire) begin
                        state_next = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_accept) begin
                        state_next = (count_next < DEPTH_C) ? ST_REQ : ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (count_next < DEPTH_C) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            req_pc_reg      <= RESET_PC;
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            count_reg       <= count_next;
            if (req_fire) begin
                req_pc_reg <= pc_reg;
            end
            if (redirect_valid) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + AW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                end
            end
        end
    end

    // FIFO storage has no reset; the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_mem[wr_ptr_reg] <= imem_rdata;
            fifo_pc_mem[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    // ---------------------------------------------------------------------
    // Decode-side outputs
    // ---------------------------------------------------------------------
    assign instr_valid = (count_reg != '0);
    assign instr       = instr_valid ? fifo_instr_mem[rd_ptr_reg] : 32'h0;
    assign instr_pc    = instr_valid ? fifo_pc_mem[rd_ptr_reg] : '0;
    assign opcode      = instr[31:26];

`ifdef IFU_PERF_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating performance counters
    // ---------------------------------------------------------------------
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_reg <= 32'h0;
            perf_flush_cnt_reg <= 32'h0;
        end else begin
            if (pop && (perf_fetch_cnt_reg != 32'hFFFF_FFFF)) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt_reg != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_reg;
    assign perf_flush_cnt = perf_flush_cnt_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. A small memory responder answers each granted
// fetch after a configurable delay, returning a fixed function of the address.
// The directed scenarios cover reset, sequential fetch, opcode extraction,
// FIFO full, redirect with a response in flight, PC wrap and reset during an
// outstanding fetch. A randomized run is checked against a reference model
// that tracks only the expected next fetch address, the expected next
// consumed PC and the number of buffered instructions.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int          PC_W     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    instr_fetch_unit #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder state
    bit          rsp_pend = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    int          rsp_cnt  = 0;
    int          rsp_min  = 0;
    int          rsp_max  = 0;

    // Observed transactions
    logic [31:0] fire_q[$];
    logic [31:0] cons_pc_q[$];
    logic [31:0] cons_ins_q[$];
    logic [5:0]  cons_op_q[$];
    bit          t_fired;
    bit          t_got;
    bit          t_popped;

    // Memory contents: two fixed words for the opcode scenario, hash elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h8C08_0004;
        if (a == 32'h0000_0204) return 32'h0000_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic clear_q();
        fire_q.delete();
        cons_pc_q.delete();
        cons_ins_q.delete();
        cons_op_q.delete();
    endtask

    // One clock: called at a negedge, samples outputs, drives inputs for the
    // coming posedge, records transactions and returns at the next negedge.
    task automatic tick(input bit gnt_allow, input bit ready_v, input bit redir,
                        input logic [31:0] rpc, input bit spurious);
        logic        req_o;
        logic        v_o;
        logic [31:0] addr_o;
        logic [31:0] pc_o;
        logic [31:0] ins_o;
        logic [5:0]  op_o;
        bit          rv;
        logic [31:0] rd;
        req_o  = imem_req;
        v_o    = instr_valid;
        addr_o = imem_addr;
        pc_o   = instr_pc;
        ins_o  = instr;
        op_o   = opcode;
        rv = 1'b0;
        rd = $urandom;
        if (rsp_pend) begin
            if (rsp_cnt == 0) begin
                rv = 1'b1;
                rd = memf(rsp_addr);
            end
        end else if (spurious) begin
            rv = 1'b1;
        end
        imem_gnt       = gnt_allow && (req_o === 1'b1);
        imem_rvalid    = rv;
        imem_rdata     = rd;
        instr_ready    = ready_v;
        redirect_valid = redir;
        redirect_pc    = rpc;
        t_fired  = (req_o === 1'b1) && gnt_allow;
        t_popped = (v_o === 1'b1) && ready_v;
        t_got    = rsp_pend && rv;
        if (t_fired) fire_q.push_back(addr_o);
        if (t_popped) begin
            cons_pc_q.push_back(pc_o);
            cons_ins_q.push_back(ins_o);
            cons_op_q.push_back(op_o);
            $display("[TB] %0t decode pc=%08h instr=%08h opcode=%02h", $time, pc_o, ins_o, op_o);
        end
        if (t_got) rsp_pend = 1'b0;
        else if (rsp_pend) rsp_cnt = rsp_cnt - 1;
        if (t_fired) begin
            rsp_pend = 1'b1;
            rsp_addr = addr_o;
            rsp_cnt  = int'($urandom_range(rsp_max, rsp_min));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rsp_pend = 1'b0;
        clear_q();
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr got=%08h exp=%08h", imem_addr, RESET_PC); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%08h exp=0", instr); end
        n_tests++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%08h exp=0", instr_pc); end
        n_tests++; if (opcode !== 6'h0) begin n_fail++; $display("FAIL reset_opcode got=%02h exp=0", opcode); end
`ifdef IFU_PERF_CNT_EN
        n_tests++; if (perf_fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetch got=%0d exp=0", perf_fetch_cnt); end
        n_tests++; if (perf_flush_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf_flush got=%0d exp=0", perf_flush_cnt); end
`endif
        $display("[TB] test_reset done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_sequential_fetch();
        bit lat_checked;
        lat_checked = 1'b0;
        do_reset();
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 40 && cons_pc_q.size() < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (t_got && !lat_checked) begin
                lat_checked = 1'b1;
                n_tests++;
                if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL seq_latency got=%b exp=1", instr_valid); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (fire_q.size() <= i) begin n_fail++; $display("FAIL seq_addr%0d got=none exp=%08h", i, 4 * i); end
            else if (fire_q[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d got=%08h exp=%08h", i, fire_q[i], 4 * i); end
            n_tests++;
            if (cons_pc_q.size() <= i) begin n_fail++; $display("FAIL seq_pc%0d got=none exp=%08h", i, 4 * i); end
            else if (cons_pc_q[i] !== 32'(4 * i) || cons_ins_q[i] !== memf(32'(4 * i))) begin
                n_fail++;
                $display("FAIL seq_pc%0d got=%08h/%08h exp=%08h/%08h", i, cons_pc_q[i], cons_ins_q[i], 4 * i, memf(32'(4 * i)));
            end
        end
        $display("[TB] test_sequential_fetch done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_opcode();
        do_reset();
        rsp_min = 0; rsp_max = 1;
        tick(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        clear_q();
        for (int i = 0; i < 40 && cons_pc_q.size() < 2; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (cons_pc_q.size() < 2) begin n_fail++; $display("FAIL opcode_count got=%0d exp=2", cons_pc_q.size()); end
        else begin
            if (cons_op_q[0] !== 6'h23 || cons_ins_q[0] !== 32'h8C08_0004 || cons_pc_q[0] !== 32'h200) begin
                n_fail++; $display("FAIL opcode_lw got=%02h/%08h exp=23/8c080004", cons_op_q[0], cons_ins_q[0]);
            end
            n_tests++;
            if (cons_op_q[1] !== 6'h00 || cons_ins_q[1] !== 32'h0) begin
                n_fail++; $display("FAIL opcode_zero got=%02h/%08h exp=00/00000000", cons_op_q[1], cons_ins_q[1]);
            end
        end
        $display("[TB] test_opcode done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_fifo_full();
        do_reset();
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (fire_q.size() !== 2) begin n_fail++; $display("FAIL full_fires got=%0d exp=2", fire_q.size()); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got=%b exp=0", imem_req); end
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL full_head got=%b/%08h exp=1/00000000", instr_valid, instr_pc); end
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (fire_q.size() !== 3) begin n_fail++; $display("FAIL full_refill got=%0d exp=3", fire_q.size()); end
        else begin
            n_tests++; if (fire_q[2] !== 32'h8) begin n_fail++; $display("FAIL full_refill_addr got=%08h exp=00000008", fire_q[2]); end
        end
        n_tests++; if (imem_req !== 1'b0 || instr_pc !== 32'h4) begin n_fail++; $display("FAIL full_after got=%b/%08h exp=0/00000004", imem_req, instr_pc); end
        $display("[TB] test_fifo_full done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_redirect_drop();
        bit early;
        early = 1'b0;
        do_reset();
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 10 && fire_q.size() < 1; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        rsp_min = 3; rsp_max = 3;
        for (int i = 0; i < 10 && fire_q.size() < 2; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (instr_valid !== 1'b1 || rsp_pend !== 1'b1) begin n_fail++; $display("FAIL redir_setup got=%b/%b exp=1/1", instr_valid, rsp_pend); end
        tick(1'b1, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", instr_valid); end
        clear_q();
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 30 && cons_pc_q.size() < 1; i++) begin
            if (imem_req === 1'b1 && rsp_pend) early = 1'b1;
            tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        n_tests++; if (early) begin n_fail++; $display("FAIL redir_early_req got=1 exp=0"); end
        n_tests++;
        if (fire_q.size() < 1) begin n_fail++; $display("FAIL redir_addr got=none exp=00000100"); end
        else if (fire_q[0] !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%08h exp=00000100", fire_q[0]); end
        n_tests++;
        if (cons_pc_q.size() < 1) begin n_fail++; $display("FAIL redir_pc got=none exp=00000100"); end
        else if (cons_pc_q[0] !== 32'h100 || cons_ins_q[0] !== memf(32'h100)) begin
            n_fail++; $display("FAIL redir_pc got=%08h/%08h exp=00000100/%08h", cons_pc_q[0], cons_ins_q[0], memf(32'h100));
        end
        $display("[TB] test_redirect_drop done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_pc_wrap();
        do_reset();
        rsp_min = 0; rsp_max = 0;
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        clear_q();
        for (int i = 0; i < 30 && cons_pc_q.size() < 2; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (fire_q.size() < 2) begin n_fail++; $display("FAIL wrap_fires got=%0d exp>=2", fire_q.size()); end
        else if (fire_q[0] !== 32'hFFFF_FFFC || fire_q[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr got=%08h,%08h exp=fffffffc,00000000", fire_q[0], fire_q[1]);
        end
        n_tests++;
        if (cons_pc_q.size() < 2) begin n_fail++; $display("FAIL wrap_pc got=%0d entries exp=2", cons_pc_q.size()); end
        else if (cons_pc_q[0] !== 32'hFFFF_FFFC || cons_pc_q[1] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pc got=%08h,%08h exp=fffffffc,00000000", cons_pc_q[0], cons_pc_q[1]);
        end
        $display("[TB] test_pc_wrap done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_mid_resp();
        do_reset();
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 10 && fire_q.size() < 1; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        rsp_min = 4; rsp_max = 4;
        for (int i = 0; i < 10 && fire_q.size() < 2; i++) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin n_fail++; $display("FAIL midrst_req got=%b/%08h exp=0/%08h", imem_req, imem_addr, RESET_PC); end
        n_tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || opcode !== 6'h0) begin
            n_fail++; $display("FAIL midrst_head got=%b/%08h/%08h/%02h exp=0/0/0/0", instr_valid, instr, instr_pc, opcode);
        end
        rst = 1'b0;
        clear_q();
        rsp_cnt = 0;   // stale response arrives now, with nothing in flight
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale got=%b exp=0", instr_valid); end
        rsp_min = 0; rsp_max = 0;
        for (int i = 0; i < 30 && cons_pc_q.size() < 1; i++) tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        n_tests++;
        if (cons_pc_q.size() < 1) begin n_fail++; $display("FAIL midrst_first got=none exp=%08h", RESET_PC); end
        else if (cons_pc_q[0] !== RESET_PC || cons_ins_q[0] !== memf(RESET_PC)) begin
            n_fail++; $display("FAIL midrst_first got=%08h/%08h exp=%08h/%08h", cons_pc_q[0], cons_ins_q[0], RESET_PC, memf(RESET_PC));
        end
        $display("[TB] test_reset_mid_resp done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_random();
        logic [31:0] exp_fetch;
        logic [31:0] exp_cons;
        int          occ;
        bit          m_drop;
        bit          fresh;
        bit          exp_req;
        bit          g, r, redir, spur;
        logic [31:0] rpc;
        int          n_pops;
        int          n_redir;
        do_reset();
        rsp_min = 0; rsp_max = 2;
        exp_fetch = RESET_PC;
        exp_cons  = RESET_PC;
        occ = 0; m_drop = 1'b0; fresh = 1'b1; n_pops = 0; n_redir = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_req = !rsp_pend && (occ < DEPTH) && !fresh;
            n_tests++;
            if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req); end
            n_tests++;
            if (instr_valid !== (occ != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, instr_valid, occ != 0); end
            if (instr_valid === 1'b1 && occ != 0) begin
                n_tests++;
                if (instr_pc !== exp_cons || instr !== memf(exp_cons) || opcode !== memf(exp_cons) >> 26) begin
                    n_fail++;
                    $display("FAIL rnd_head cyc=%0d got=%08h/%08h/%02h exp=%08h/%08h", cyc, instr_pc, instr, opcode, exp_cons, memf(exp_cons));
                end
            end
            if (imem_req === 1'b1 && exp_req) begin
                n_tests++;
                if (imem_addr !== exp_fetch) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%08h exp=%08h", cyc, imem_addr, exp_fetch); end
            end
            g     = ($urandom_range(9, 0) < 7);
            r     = ($urandom_range(9, 0) < 6);
            redir = ($urandom_range(19, 0) == 0);
            spur  = ($urandom_range(19, 0) == 0);
            rpc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                                : ($urandom & 32'h0000_0FFF);
            tick(g, r, redir, rpc, spur);
            if (t_popped) begin
                n_pops++;
                exp_cons = exp_cons + 32'd4;
                if (occ > 0) occ--;
            end
            if (t_got) begin
                if (!m_drop && !redir) occ++;
                m_drop = 1'b0;
            end
            if (redir && rsp_pend) m_drop = 1'b1;
            if (t_fired) exp_fetch = exp_fetch + 32'd4;
            if (redir) begin
                n_redir++;
                occ       = 0;
                exp_fetch = rpc & ~32'd3;
                exp_cons  = rpc & ~32'd3;
            end
            fresh = 1'b0;
        end
`ifdef IFU_PERF_CNT_EN
        n_tests++; if (perf_fetch_cnt !== 32'(n_pops)) begin n_fail++; $display("FAIL rnd_perf_fetch got=%0d exp=%0d", perf_fetch_cnt, n_pops); end
        n_tests++; if (perf_flush_cnt !== 32'(n_redir)) begin n_fail++; $display("FAIL rnd_perf_flush got=%0d exp=%0d", perf_flush_cnt, n_redir); end
`endif
        $display("[TB] test_random done: %0d decodes, %0d redirects", n_pops, n_redir);
    endtask

    // ---------------------------------------------------------------------
    initial begin
        @(negedge clk);
        test_reset();
        test_sequential_fetch();
        test_opcode();
        test_fifo_full();
        test_redirect_drop();
        test_pc_wrap();
        test_reset_mid_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
